priority_encoder_rr: RTL and testbench
======================================

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter N SHALL default to 8 and SHALL be the request-vector width; it is a power of two, 2..64.
REQ-002 Derived width W SHALL equal log2(N), default 3, and SHALL NOT be overridable.
REQ-003 CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 en  input  1  SHALL be the active-high sample enable; while low, no new requests are sampled.
REQ-006 mode  input  1  SHALL select arbitration: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 req  input  N  SHALL be the request vector, one bit per requester.
REQ-008 out_ready  input  1  SHALL be the consumer-ready handshake.
REQ-009 out_valid  output  1  SHALL be the registered flag marking a held encoded result.
REQ-010 out_idx  output  W  SHALL be the registered binary index of the winning requester.
REQ-011 out_onehot  output  N  SHALL be the registered one-hot form of out_idx (all zero when out_valid=0).
REQ-012 ptr  output  W  SHALL expose the round-robin pointer for debug and LEDs.

Function
REQ-013 Output register SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load SHALL be asserted when en=1 and (state EMPTY, or FULL with out_ready=1).
REQ-015 On load with req!=0, the block SHALL enter FULL and register the winner into out_idx and out_onehot, one-cycle latency from req to out_*.
REQ-016 On load with req=0, the block SHALL enter EMPTY; out_idx holds its value, out_onehot clears.
REQ-017 In FULL with out_ready=0, out_valid, out_idx and out_onehot SHALL hold regardless of req, en or mode.
REQ-018 In FULL with out_ready=1 and en=0, the block SHALL enter EMPTY next cycle (consume, no refill).
REQ-019 In FULL with out_ready=1 and en=1, consume and refill SHALL occur in the same cycle (back-to-back, no bubble).
REQ-020 mode=0: winner SHALL be the highest set index of req; ptr unchanged.
REQ-021 mode=1: winner SHALL be the first set bit scanning upward from index ptr inclusive, wrapping N-1 -> 0.
REQ-022 mode=1 with a winner on load: ptr SHALL update to (winner+1) mod N; wrap from N-1 to 0 is required.
REQ-023 mode is sampled only on load; a mode change SHALL NOT alter a held result.
REQ-024 Arithmetic SHALL be W bits unsigned, modulo N; no ptr value outside 0..N-1 is reachable.
REQ-025 A single set req bit SHALL win in either mode, independent of ptr.

Reset
REQ-026 With resetn=0 at a clock edge: state EMPTY, out_valid=0, out_idx=0, out_onehot=0, ptr=0.
REQ-027 Reset SHALL take priority over load and handshake, including mid-stall in FULL; the held result is discarded.
REQ-028 No output SHALL change between edges; resetn is not asynchronous.

Verification (N=8)
REQ-029 Reset then en=1, mode=0, req=8'b0000_1010 -> next cycle out_valid=1, out_idx=3, out_onehot=8'b0000_1000, ptr=0.
REQ-030 mode=1, req=8'hFF, out_ready=1 held 9 cycles -> out_idx sequence 0,1,...,7,0; ptr wraps 7->0 after index 7.
REQ-031 FULL with out_idx=5, out_ready=0 for 4 cycles while req changes to 8'h01 -> out_idx stays 5; out_ready=1 then gives out_idx=0 next cycle.
REQ-032 en=1, req=8'h00 -> out_valid=0, out_onehot=0; then en=0, req=8'h80 -> out_valid stays 0.
REQ-033 mode=1, ptr=6, req=8'b0010_0001 -> out_idx=0, ptr=1 (wrap scan past 6,7).
REQ-034 FULL, out_ready=0, resetn=0 one cycle -> out_valid=0, out_idx=0, ptr=0 next edge.

Source files
------------

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
//   Registered priority encoder with selectable fixed-priority or round-robin
//   arbitration. A two-state output register (EMPTY/FULL) holds one encoded
//   winner at a time. The consumer drains it with a valid/ready handshake.
//
// Handshake: a result transfers on a rising edge where out_valid=1 and
//   out_ready=1. While out_valid=1 and out_ready=0, out_valid, out_idx and
//   out_onehot hold steady whatever req, en or mode do. A new sample (load) is
//   taken when en=1 and the register is EMPTY or is being drained that same
//   cycle, so a continuous stream has no bubbles.
//
// Ports
//   CLOCK_50    in   single clock, rising edge
//   resetn      in   synchronous active-low reset
//   en          in   sample enable
//   mode        in   0 = fixed priority (highest index wins), 1 = round-robin
//   req         in   N request bits
//   out_ready   in   consumer ready
//   out_valid   out  result held
//   out_idx     out  binary index of the winner
//   out_onehot  out  one-hot form of out_idx, zero while out_valid=0
//   ptr         out  round-robin pointer (debug / LEDs)
//   fsm_state   out  raw output-register state (0 = EMPTY, 1 = FULL)

module priority_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] ptr,
  output logic         fsm_state
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic         load;
  logic         drain;
  logic         any_req;
  logic [W-1:0] rr_cand;
  logic [W-1:0] rr_win;
  logic         rr_found;
  logic [W-1:0] fp_win;
  logic [W-1:0] win;
  logic [N-1:0] win_onehot;

  assign any_req   = |req;
  assign load      = en && ((state == EMPTY) || out_ready);
  assign drain     = (state == FULL) && out_ready;
  assign out_valid = (state == FULL);
  assign fsm_state = state;

  // Round-robin scan: start at ptr and walk upward. Adding in W bits wraps
  // N-1 -> 0 for free because N is a power of two.
  always_comb begin
    rr_cand  = ptr;
    rr_win   = ptr;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      rr_cand = ptr + W'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_win   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Fixed priority: the last set bit seen in an upward scan is the highest.
  always_comb begin
    fp_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fp_win = W'(i);
    end
  end

  always_comb begin
    win             = mode ? rr_win : fp_win;
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = any_req ? FULL : EMPTY;
    end else if (drain) begin
      next_state = EMPTY;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= EMPTY;
    else         state <= next_state;
  end

  // out_idx keeps its last winner when the register empties; only the
  // one-hot copy is cleared so it reads zero whenever out_valid is low.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else if (load) begin
      if (any_req) begin
        out_idx    <= win;
        out_onehot <= win_onehot;
        if (mode) ptr <= win + W'(1);
      end else begin
        out_onehot <= '0;
      end
    end else if (drain) begin
      out_onehot <= '0;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
module tb_priority_encoder_rr;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int PW = 1 + W + N + W;

  // clock / reset
  logic         CLOCK_50 = 1'b0;
  logic         resetn;
  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [W-1:0] ptr;
  logic         fsm_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  priority_encoder_rr #(.N(N)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .en        (en),
    .mode      (mode),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_onehot(out_onehot),
    .ptr       (ptr),
    .fsm_state (fsm_state)
  );

  // scoreboard: {valid, idx, onehot, ptr}
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got;
  logic [PW-1:0] exp_v;
  int passed = 0;
  int total  = 0;

  // reference model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_idx   = '0;
  logic [N-1:0] m_oh    = '0;
  logic [W-1:0] m_ptr   = '0;

  function automatic int m_win(input logic [N-1:0] r, input logic m, input int p);
    int j;
    if (!m) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      j = p;
      for (int k = 0; k < N; k++) begin
        if (r[j]) return j;
        j = (j + 1) % N;
      end
    end
    return 0;
  endfunction

  // Model the edge from the current inputs, push the expectation, then
  // advance one clock and settle #1 past the edge.
  task automatic tick();
    int w;
    if (!resetn) begin
      m_valid = 1'b0; m_idx = '0; m_oh = '0; m_ptr = '0;
    end else if (en && (!m_valid || out_ready)) begin
      if (req != '0) begin
        w       = m_win(req, mode, int'(m_ptr));
        m_valid = 1'b1;
        m_idx   = W'(w);
        m_oh    = N'(1) << w;
        if (mode) m_ptr = W'((w + 1) % N);
      end else begin
        m_valid = 1'b0;
        m_oh    = '0;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_oh    = '0;
    end
    exp_q.push_back({m_valid, m_idx, m_oh, m_ptr});
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic r_n, input logic e, input logic m,
                       input logic [N-1:0] r, input logic rdy);
    resetn = r_n; en = e; mode = m; req = r; out_ready = rdy;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    tick();
    tick();
    repeat (2) begin
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL reset_sb got=%h exp=%h", got, exp_v); else passed++;
      break;
    end
    void'(exp_q.pop_front());
    total++;
    if ({out_valid, out_idx, out_onehot, ptr, fsm_state} !== '0)
      $display("FAIL reset_zero got v=%b idx=%0d oh=%h ptr=%0d exp all 0", out_valid, out_idx, out_onehot, ptr);
    else passed++;
  endtask

  task automatic test_fixed();
    drive(1'b1, 1'b1, 1'b0, 8'b0000_1010, 1'b1);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL fixed_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_onehot !== 8'h08 || ptr !== 3'd0)
      $display("FAIL fixed_0a got v=%b idx=%0d oh=%h ptr=%0d exp v=1 idx=3 oh=08 ptr=0", out_valid, out_idx, out_onehot, ptr);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, N'($urandom_range(1, 255)), 1'b1);
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL fixed_rand_sb got=%h exp=%h", got, exp_v); else passed++;
    end
  endtask

  task automatic test_rr_sweep();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL rr_sweep_sb got=%h exp=%h", got, exp_v); else passed++;
      total++;
      if (out_idx !== W'(i % N) || ptr !== W'((i + 1) % N))
        $display("FAIL rr_sweep_seq step=%0d got idx=%0d ptr=%0d exp idx=%0d ptr=%0d", i, out_idx, ptr, i % N, (i + 1) % N);
      else passed++;
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 8'h20, 1'b1);
    tick();
    void'(exp_q.pop_front());
    total++;
    if (out_idx !== 3'd5 || out_valid !== 1'b1) $display("FAIL stall_setup got idx=%0d v=%b exp idx=5 v=1", out_idx, out_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], i[1], 8'h01, 1'b0);
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL stall_sb got=%h exp=%h", got, exp_v); else passed++;
      total++;
      if (out_idx !== 3'd5 || out_onehot !== 8'h20 || out_valid !== 1'b1)
        $display("FAIL stall_hold got idx=%0d oh=%h v=%b exp idx=5 oh=20 v=1", out_idx, out_onehot, out_valid);
      else passed++;
    end
    drive(1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL stall_release_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (out_idx !== 3'd0 || out_valid !== 1'b1) $display("FAIL stall_release got idx=%0d v=%b exp idx=0 v=1", out_idx, out_valid); else passed++;
    // consume with en low: no refill
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL drain_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (out_valid !== 1'b0 || out_onehot !== 8'h00 || out_idx !== 3'd0)
      $display("FAIL drain got v=%b oh=%h idx=%0d exp v=0 oh=00 idx=0", out_valid, out_onehot, out_idx);
    else passed++;
  endtask

  task automatic test_empty();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL empty_sb got=%h exp=%h", got, exp_v); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h80, 1'b1);
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL en_low_sb got=%h exp=%h", got, exp_v); else passed++;
      total++;
      if (out_valid !== 1'b0 || out_onehot !== 8'h00) $display("FAIL en_low got v=%b oh=%h exp v=0 oh=00", out_valid, out_onehot); else passed++;
    end
  endtask

  task automatic test_wrap_scan();
    drive(1'b1, 1'b1, 1'b1, 8'h20, 1'b1);
    tick();
    void'(exp_q.pop_front());
    total++;
    if (ptr !== 3'd6) $display("FAIL wrap_setup got ptr=%0d exp 6", ptr); else passed++;
    drive(1'b1, 1'b1, 1'b1, 8'b0010_0001, 1'b1);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL wrap_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (out_idx !== 3'd0 || ptr !== 3'd1) $display("FAIL wrap_scan got idx=%0d ptr=%0d exp idx=0 ptr=1", out_idx, ptr); else passed++;
  endtask

  task automatic test_single_bit();
    for (int i = 0; i < 2 * N; i++) begin
      drive(1'b1, 1'b1, i[0], N'(1) << (i % N), 1'b1);
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL single_sb got=%h exp=%h", got, exp_v); else passed++;
      total++;
      if (out_idx !== W'(i % N)) $display("FAIL single_bit got idx=%0d exp %0d", out_idx, i % N); else passed++;
    end
  endtask

  task automatic test_reset_stall();
    drive(1'b1, 1'b1, 1'b1, 8'h10, 1'b1);
    tick();
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) $display("FAIL reset_stall_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || ptr !== 3'd0 || out_onehot !== 8'h00)
      $display("FAIL reset_stall got v=%b idx=%0d ptr=%0d oh=%h exp all 0", out_valid, out_idx, ptr, out_onehot);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? 8'h00 : N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
      got = {out_valid, out_idx, out_onehot, ptr}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL random_sb cycle=%0d got=%h exp=%h", i, got, exp_v); else passed++;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_stall();
    test_empty();
    test_wrap_scan();
    test_single_bit();
    test_reset_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
